// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: store-strobe encodings and FSM states.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package mem_pkg;

    // One-hot write strobes, same encoding the core's store path emits.
    localparam logic [2:0] WE_NONE = 3'b000;
    localparam logic [2:0] WE_SB   = 3'b100;
    localparam logic [2:0] WE_SH   = 3'b010;
    localparam logic [2:0] WE_SW   = 3'b001;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    // Only a legal one-hot strobe is a store; every other nonzero code degrades to a read.
    function automatic logic we_is_store(input logic [2:0] we);
        return (we == WE_SB) || (we == WE_SH) || (we == WE_SW);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on a tie the port not granted last wins.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       any
);

    // Tie goes to the other port; a lone request simply wins.
    always_comb begin
        any    = |req;
        winner = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous RAM between two requesters with round-robin fairness.
// Latency: gnt 1 cycle after req sampled; rvalid 2 cycles after req (write) or 2+RD_LATENCY (read).
// Backpressure: req is held until gnt; one access in flight, next arbitrated during RESP.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic [2:0]        p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic [2:0]        p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [2:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int              CNT_W    = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LATENCY - 1);

    arb_state_t        state_q, state_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic              last_q;      // port granted most recently
    logic              owner_q;     // port owning the access in flight
    logic              store_q;     // access in flight is a legal store

    logic              win;
    logic              any_req;
    logic [2:0]        win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    logic              arb_take;    // winner's payload is captured this cycle
    logic              resp_nxt;    // next cycle is RESP
    logic              rsp_from_ram;
    logic [DATA_W-1:0] rsp_dat;

    rr_arbiter2 u_rr (
        .req    ({p1_req, p0_req}),
        .last   (last_q),
        .winner (win),
        .any    (any_req)
    );

    // Select the winning port's payload for capture.
    always_comb begin
        win_we    = win ? p1_we    : p0_we;
        win_addr  = win ? p1_addr  : p0_addr;
        win_wdata = win ? p1_wdata : p0_wdata;
        rsp_dat   = rsp_from_ram ? ram_rdata : '0;
    end

    // Next-state logic: arbitrate in IDLE/RESP, branch on access type in ISSUE, count down in WAIT.
    always_comb begin
        state_nxt    = state_q;
        cnt_nxt      = cnt_q;
        arb_take     = 1'b0;
        resp_nxt     = 1'b0;
        rsp_from_ram = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                if (any_req) begin
                    state_nxt = ISSUE;
                    arb_take  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ISSUE: begin
                if (store_q) begin
                    state_nxt = RESP;
                    resp_nxt  = 1'b1;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_nxt    = RESP;
                    resp_nxt     = 1'b1;
                    rsp_from_ram = 1'b1;
                end else begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counter and captured transaction context.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            if (arb_take) begin
                last_q  <= win;
                owner_q <= win;
                store_q <= we_is_store(win_we);
            end
        end
    end

    // RAM-side outputs: strobe only for the ISSUE cycle, address/data held between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we    <= WE_NONE;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_we <= (arb_take && we_is_store(win_we)) ? win_we : WE_NONE;
            if (arb_take) begin
                ram_addr  <= win_addr;
                ram_wdata <= win_wdata;
            end
        end
    end

    // Requester-side outputs: grant pulse in ISSUE, completion pulse and data in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_gnt    <= arb_take && !win;
            p1_gnt    <= arb_take &&  win;
            p0_rvalid <= resp_nxt && !owner_q;
            p1_rvalid <= resp_nxt &&  owner_q;
            p0_rdata  <= (resp_nxt && !owner_q) ? rsp_dat : '0;
            p1_rdata  <= (resp_nxt &&  owner_q) ? rsp_dat : '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, corner sequences and a random scoreboard.
// Latency: instances at RD_LATENCY 1 and 3, each with its own pipelined RAM model.
// Backpressure: requesters hold req until gnt, then drop it.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p1_req;
    logic [2:0]  p0_we, p1_we;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;

    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic [2:0]  ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    logic        d3_p0_gnt, d3_p1_gnt, d3_p0_rvalid, d3_p1_rvalid;
    logic [31:0] d3_p0_rdata, d3_p1_rdata;
    logic [2:0]  d3_ram_we;
    logic [31:0] d3_ram_addr, d3_ram_wdata, d3_ram_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(d3_p0_gnt), .p0_rvalid(d3_p0_rvalid), .p0_rdata(d3_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(d3_p1_gnt), .p1_rvalid(d3_p1_rvalid), .p1_rdata(d3_p1_rdata),
        .ram_we(d3_ram_we), .ram_addr(d3_ram_addr), .ram_wdata(d3_ram_wdata),
        .ram_rdata(d3_ram_rdata)
    );

    // RAM models: word array indexed by addr[5:2], read data delayed by the latency in cycles.
    logic [31:0] mem [16];
    logic [31:0] pipe1;
    logic [31:0] pipe3 [3];

    always @(posedge clk) begin
        pipe1    <= mem[ram_addr[5:2]];
        pipe3[0] <= mem[d3_ram_addr[5:2]];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign ram_rdata    = pipe1;
    assign d3_ram_rdata = pipe3[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic p, input logic r, input logic [2:0] we,
                         input logic [31:0] a, input logic [31:0] d);
        if (p) begin p1_req = r; p1_we = we; p1_addr = a; p1_wdata = d; end
        else   begin p0_req = r; p0_we = we; p0_addr = a; p0_wdata = d; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic gnt_of(input logic p);    return p ? p1_gnt    : p0_gnt;    endfunction
    function automatic logic rv_of(input logic p);     return p ? p1_rvalid : p0_rvalid; endfunction
    function automatic logic [31:0] rd_of(input logic p); return p ? p1_rdata : p0_rdata; endfunction
    function automatic logic legal_store(input logic [2:0] we);
        return we == 3'b100 || we == 3'b010 || we == 3'b001;
    endfunction

    typedef struct {
        logic        port;
        logic [2:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  exp_we;
        int          exp_rv_cyc;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs [7];

    // One isolated access from IDLE; cycle c counts from the cycle req was sampled (c = 0).
    task automatic run_vec(input int i, input vec_t v);
        drive(v.port, 1'b1, v.we, v.addr, v.wdata);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("v%0d c%0d gnt", i, c), gnt_of(v.port), c == 1);
            check($sformatf("v%0d c%0d other", i, c),
                  {gnt_of(!v.port), rv_of(!v.port), rd_of(!v.port)}, 0);
            check($sformatf("v%0d c%0d ram_we", i, c), ram_we, (c == 1) ? v.exp_we : 3'b000);
            check($sformatf("v%0d c%0d rvalid", i, c), rv_of(v.port), c == v.exp_rv_cyc);
            check($sformatf("v%0d c%0d rdata", i, c), rd_of(v.port),
                  (c == v.exp_rv_cyc) ? v.exp_rdata : 32'h0);
            if (c == 1) begin
                check($sformatf("v%0d addr", i), ram_addr, v.addr);
                check($sformatf("v%0d wdata", i), ram_wdata, v.wdata);
                drive(v.port, 1'b0, v.we, v.addr, v.wdata);
            end
        end
    endtask

    typedef struct { int due; logic [31:0] data; } exp_t;

    // Random traffic scored against a transaction-level model of arbitration and latency.
    task automatic random_phase(input int ncyc);
        logic [2:0]  we_tab [6];
        logic        r_req [2];
        logic [2:0]  r_we [2];
        logic [31:0] r_addr [2];
        logic [31:0] r_wdata [2];
        logic        prev_req [2];
        logic        prev_rv;
        logic        last;
        exp_t        q [2][$];
        exp_t        e;
        int          cyc;
        we_tab[0] = 3'b000; we_tab[1] = 3'b100; we_tab[2] = 3'b010;
        we_tab[3] = 3'b001; we_tab[4] = 3'b011; we_tab[5] = 3'b111;
        for (int p = 0; p < 2; p++) begin
            r_req[p] = 1'b0; r_we[p] = 3'b000; r_addr[p] = 32'h0; r_wdata[p] = 32'h0;
            prev_req[p] = 1'b0;
        end
        prev_rv = 1'b0;
        last    = 1'b1;
        cyc     = 0;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            cyc++;
            check("rnd dual gnt", p0_gnt & p1_gnt, 0);
            if (prev_rv && (prev_req[0] || prev_req[1]))
                check("rnd b2b gnt", p0_gnt | p1_gnt, 1);
            if (!p0_gnt && !p1_gnt) check("rnd idle ram_we", ram_we, 3'b000);
            prev_rv = p0_rvalid | p1_rvalid;
            for (int p = 0; p < 2; p++) begin
                if (gnt_of(p[0])) begin
                    if (prev_req[0] && prev_req[1]) check("rnd rr", p, !last);
                    last = p[0];
                    check("rnd ram_we", ram_we, legal_store(r_we[p]) ? r_we[p] : 3'b000);
                    check("rnd ram_addr", ram_addr, r_addr[p]);
                    e.due  = legal_store(r_we[p]) ? cyc + 1 : cyc + 2;
                    e.data = legal_store(r_we[p]) ? 32'h0 : mem[r_addr[p][5:2]];
                    q[p].push_back(e);
                    r_req[p] = 1'b0;
                end
                if (rv_of(p[0])) begin
                    if (q[p].size() == 0) begin
                        check($sformatf("rnd p%0d spurious rvalid", p), 1, 0);
                    end else begin
                        e = q[p].pop_front();
                        check($sformatf("rnd p%0d rv time", p), cyc, e.due);
                        check($sformatf("rnd p%0d rdata", p), rd_of(p[0]), e.data);
                    end
                end else begin
                    check($sformatf("rnd p%0d rdata idle", p), rd_of(p[0]), 0);
                end
            end
            // New requests only while not draining at the end.
            for (int p = 0; p < 2; p++) begin
                if (!r_req[p] && n < ncyc - 10 && $urandom_range(0, 2) == 0) begin
                    r_req[p]   = 1'b1;
                    r_we[p]    = we_tab[$urandom_range(0, 5)];
                    r_addr[p]  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
                    r_wdata[p] = $urandom;
                end
                drive(p[0], r_req[p], r_we[p], r_addr[p], r_wdata[p]);
                prev_req[p] = r_req[p];
            end
        end
        check("rnd p0 drained", q[0].size(), 0);
        check("rnd p1 drained", q[1].size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 | i;
        mem[4] = 32'hDEADBEEF;

        vecs[0] = '{1'b0, 3'b000, 32'h10, 32'h0,        3'b000, 3, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 3'b100, 32'h20, 32'hAB,       3'b100, 2, 32'h0};
        vecs[2] = '{1'b0, 3'b001, 32'h30, 32'h12345678, 3'b001, 2, 32'h0};
        vecs[3] = '{1'b1, 3'b010, 32'h04, 32'hBEEF,     3'b010, 2, 32'h0};
        vecs[4] = '{1'b0, 3'b011, 32'h08, 32'h55,       3'b000, 3, 32'hC0DE0002};
        vecs[5] = '{1'b1, 3'b111, 32'h24, 32'h66,       3'b000, 3, 32'hC0DE0009};
        vecs[6] = '{1'b1, 3'b000, 32'h3C, 32'h0,        3'b000, 3, 32'hC0DE000F};

        @(negedge clk);
        do_reset();
        @(negedge clk);
        check("reset gnt/rvalid", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}, 0);
        check("reset rdata", {p0_rdata, p1_rdata}, 0);
        check("reset ram_we", ram_we, 3'b000);
        check("reset ram_addr/wdata", {ram_addr, ram_wdata}, 0);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Round-robin: both ports read continuously; p0 wins the first tie after reset.
        do_reset();
        drive(1'b0, 1'b1, 3'b000, 32'h04, 32'h0);
        drive(1'b1, 1'b1, 3'b000, 32'h08, 32'h0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            check($sformatf("rr c%0d p0_gnt", c), p0_gnt, c == 1 || c == 7);
            check($sformatf("rr c%0d p1_gnt", c), p1_gnt, c == 4 || c == 10);
            check($sformatf("rr c%0d p0 resp", c), {p0_rvalid, p0_rdata},
                  (c == 3 || c == 9) ? {1'b1, 32'hC0DE0001} : 33'h0);
            check($sformatf("rr c%0d p1 resp", c), {p1_rvalid, p1_rdata},
                  (c == 6 || c == 12) ? {1'b1, 32'hC0DE0002} : 33'h0);
        end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (4) @(negedge clk);

        // Reset while a read sits in WAIT: outputs clear at once, no completion follows.
        do_reset();
        drive(1'b0, 1'b1, 3'b000, 32'h10, 32'h0);
        @(negedge clk);
        check("rstw gnt", p0_gnt, 1);
        drive(1'b0, 1'b0, 3'b000, 32'h10, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rstw gnt/rvalid", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}, 0);
        check("rstw rdata", {p0_rdata, p1_rdata}, 0);
        check("rstw ram", {ram_we, ram_addr, ram_wdata}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("rstw c%0d no rvalid", c), {p0_rvalid, p1_rvalid}, 0);
        end
        run_vec(10, vecs[0]);

        // Reset during a write's ISSUE cycle drops the strobe immediately.
        do_reset();
        drive(1'b1, 1'b1, 3'b001, 32'h20, 32'hCAFE);
        @(posedge clk);
        #1;
        check("rsti strobe up", ram_we, 3'b001);
        rst_n = 1'b0;
        #1;
        check("rsti strobe drop", ram_we, 3'b000);
        drive(1'b1, 1'b0, 3'b001, 32'h20, 32'hCAFE);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("rsti c%0d no rvalid", c), p1_rvalid, 0);
        end

        // RD_LATENCY = 3: data sampled from the RAM in cycle 4, rvalid in cycle 5.
        do_reset();
        drive(1'b0, 1'b1, 3'b000, 32'h10, 32'h0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("lat3 gnt", d3_p0_gnt, 1);
                drive(1'b0, 1'b0, 3'b000, 32'h10, 32'h0);
            end
            if (c == 2) mem[4] = 32'h12345678;
            check($sformatf("lat3 c%0d rvalid", c), d3_p0_rvalid, c == 5);
            check($sformatf("lat3 c%0d rdata", c), d3_p0_rdata, (c == 5) ? 32'hDEADBEEF : 32'h0);
            check($sformatf("lat3 c%0d ram_we", c), d3_ram_we, 3'b000);
        end
        mem[4] = 32'hDEADBEEF;

        do_reset();
        random_phase(3000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
